// File: rtl/fountain_v2_keystream.sv
// Fountain v2 keystream core: key/IV load, fixed warm-up, then XORs a keystream onto
// DATA_W-bit words with STEP_W unrolled shifts per clock.
module fountain_v2_keystream #(
  parameter int DATA_W      = 64,
  parameter int STEP_W      = 1,
  parameter int WARMUP_BITS = 256
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [127:0]      key,
  input  logic [95:0]       iv,
  output logic              busy,
  output logic              init_done,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] data_in,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] data_out
);

  localparam int WARM_CYC = WARMUP_BITS / STEP_W;
  localparam int GEN_CYC  = DATA_W / STEP_W;
  localparam logic [15:0] WARM_LAST = 16'(WARM_CYC - 1);
  localparam logic [15:0] GEN_LAST  = 16'(GEN_CYC - 1);

  typedef enum logic [2:0] {IDLE, INIT, READY, GEN, OUT} state_t;

  state_t            state_reg;
  logic [127:0]      l_reg;
  logic [127:0]      n_reg;
  logic [DATA_W-1:0] data_reg;
  logic [15:0]       cnt_reg;

  logic              warm_up;
  logic [127:0]      l_st [STEP_W+1];
  logic [127:0]      n_st [STEP_W+1];
  logic [STEP_W-1:0] z_bits;
  logic [DATA_W-1:0] data_step;

  assign warm_up = (state_reg == INIT);
  assign l_st[0] = l_reg;
  assign n_st[0] = n_reg;

  // Stage gi is exactly the gi-th serial shift, so every STEP_W yields the same stream.
  for (genvar gi = 0; gi < STEP_W; gi++) begin : g_step
    logic [127:0] l;
    logic [127:0] n;
    logic f_b, g_b, z_b;
    assign l   = l_st[gi];
    assign n   = n_st[gi];
    assign f_b = l[0] ^ l[7] ^ l[38] ^ l[70] ^ l[81] ^ l[96];
    assign g_b = l[0] ^ n[0] ^ n[26] ^ n[56] ^ n[91] ^ n[96]
               ^ (n[3] & n[67]) ^ (n[11] & n[13]) ^ (n[17] & n[18]);
    assign z_b = n[2] ^ n[15] ^ n[36] ^ n[45] ^ n[64] ^ n[73] ^ n[89] ^ l[93]
               ^ (l[8] & n[12]) ^ (l[13] & l[20]);
    assign z_bits[gi] = z_b;
    assign l_st[gi+1] = {f_b ^ (warm_up & z_b), l[127:1]};
    assign n_st[gi+1] = {g_b ^ (warm_up & z_b), n[127:1]};
  end

  // The word rotates right by STEP_W each clock; after GEN_CYC clocks every bit is back
  // in place, having met keystream bit i at position i.
  if (STEP_W == DATA_W) begin : g_full
    assign data_step = data_reg ^ z_bits;
  end else begin : g_part
    assign data_step = {data_reg[STEP_W-1:0] ^ z_bits, data_reg[DATA_W-1:STEP_W]};
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg <= IDLE;
      l_reg     <= '0;
      n_reg     <= '0;
      data_reg  <= '0;
      cnt_reg   <= '0;
    end else begin
      case (state_reg)
        IDLE: begin
          if (start) begin
            n_reg     <= key;
            l_reg     <= {32'hFFFF_FFFE, iv};
            cnt_reg   <= '0;
            state_reg <= INIT;
          end
        end
        INIT: begin
          l_reg <= l_st[STEP_W];
          n_reg <= n_st[STEP_W];
          if (cnt_reg == WARM_LAST) begin
            cnt_reg   <= '0;
            state_reg <= READY;
          end else begin
            cnt_reg <= cnt_reg + 16'd1;
          end
        end
        READY: begin
          if (start) begin
            n_reg     <= key;
            l_reg     <= {32'hFFFF_FFFE, iv};
            cnt_reg   <= '0;
            state_reg <= INIT;
          end else if (in_valid) begin
            data_reg  <= data_in;
            cnt_reg   <= '0;
            state_reg <= GEN;
          end
        end
        GEN: begin
          l_reg    <= l_st[STEP_W];
          n_reg    <= n_st[STEP_W];
          data_reg <= data_step;
          if (cnt_reg == GEN_LAST) begin
            cnt_reg   <= '0;
            state_reg <= OUT;
          end else begin
            cnt_reg <= cnt_reg + 16'd1;
          end
        end
        OUT: begin
          if (out_ready) state_reg <= READY;
        end
        default: state_reg <= IDLE;
      endcase
    end
  end

  assign busy      = (state_reg == INIT);
  assign init_done = (state_reg == READY) || (state_reg == GEN) || (state_reg == OUT);
  assign in_ready  = (state_reg == READY) && !start;
  assign out_valid = (state_reg == OUT);
  assign data_out  = data_reg;

endmodule

// File: tb/tb_fountain_v2_keystream.sv
// Directed bench for fountain_v2_keystream: STEP_W=1, 8 and 32 instances checked against
// a serial reference model of the cipher.
module tb_fountain_v2_keystream;

  logic         clk;
  logic         rst;
  logic [127:0] key;
  logic [95:0]  iv;
  logic         start_s     [3];
  logic         busy_s      [3];
  logic         init_done_s [3];
  logic         in_valid_s  [3];
  logic         in_ready_s  [3];
  logic [63:0]  data_in_s   [3];
  logic         out_valid_s [3];
  logic         out_ready_s [3];
  logic [63:0]  data_out_s  [3];

  int checks = 0;
  int errors = 0;

  logic [127:0] ml, mn;
  logic [63:0]  ks_exp [6];
  int           lat_exp [3] = '{64, 8, 2};
  logic [63:0]  pat [4] = '{64'h0, 64'hFFFF_FFFF_FFFF_FFFF, 64'h0123_4567_89AB_CDEF, 64'hA5A5_A5A5_A5A5_A5A5};

  fountain_v2_keystream #(.DATA_W(64), .STEP_W(1), .WARMUP_BITS(256)) u_s1 (
    .clk(clk), .rst(rst), .start(start_s[0]), .key(key), .iv(iv), .busy(busy_s[0]),
    .init_done(init_done_s[0]), .in_valid(in_valid_s[0]), .in_ready(in_ready_s[0]),
    .data_in(data_in_s[0]), .out_valid(out_valid_s[0]), .out_ready(out_ready_s[0]),
    .data_out(data_out_s[0]));

  fountain_v2_keystream #(.DATA_W(64), .STEP_W(8), .WARMUP_BITS(256)) u_s8 (
    .clk(clk), .rst(rst), .start(start_s[1]), .key(key), .iv(iv), .busy(busy_s[1]),
    .init_done(init_done_s[1]), .in_valid(in_valid_s[1]), .in_ready(in_ready_s[1]),
    .data_in(data_in_s[1]), .out_valid(out_valid_s[1]), .out_ready(out_ready_s[1]),
    .data_out(data_out_s[1]));

  fountain_v2_keystream #(.DATA_W(64), .STEP_W(32), .WARMUP_BITS(256)) u_s32 (
    .clk(clk), .rst(rst), .start(start_s[2]), .key(key), .iv(iv), .busy(busy_s[2]),
    .init_done(init_done_s[2]), .in_valid(in_valid_s[2]), .in_ready(in_ready_s[2]),
    .data_in(data_in_s[2]), .out_valid(out_valid_s[2]), .out_ready(out_ready_s[2]),
    .data_out(data_out_s[2]));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Serial reference: one shift, returns z.
  task automatic model_shift(input bit warm, output logic z);
    logic f, g;
    f = ml[0] ^ ml[7] ^ ml[38] ^ ml[70] ^ ml[81] ^ ml[96];
    g = ml[0] ^ mn[0] ^ mn[26] ^ mn[56] ^ mn[91] ^ mn[96]
      ^ (mn[3] & mn[67]) ^ (mn[11] & mn[13]) ^ (mn[17] & mn[18]);
    z = mn[2] ^ mn[15] ^ mn[36] ^ mn[45] ^ mn[64] ^ mn[73] ^ mn[89] ^ ml[93]
      ^ (ml[8] & mn[12]) ^ (ml[13] & ml[20]);
    ml = {f ^ (warm & z), ml[127:1]};
    mn = {g ^ (warm & z), mn[127:1]};
  endtask

  task automatic compute_ks(input logic [127:0] k, input logic [95:0] v);
    logic z;
    mn = k;
    ml = {32'hFFFF_FFFE, v};
    for (int i = 0; i < 256; i++) model_shift(1'b1, z);
    for (int w = 0; w < 6; w++) begin
      for (int i = 0; i < 64; i++) begin
        model_shift(1'b0, z);
        ks_exp[w][i] = z;
      end
    end
  endtask

  task automatic wait_init(input int idx);
    int guard = 0;
    while (!init_done_s[idx] && guard < 400) begin
      step();
      guard++;
    end
    if (guard >= 400) begin
      checks++;
      errors++;
      $display("FAIL init_timeout inst %0d: init_done=%0b required 1", idx, init_done_s[idx]);
    end
  endtask

  task automatic do_init(input int idx);
    start_s[idx] = 1'b1;
    step();
    start_s[idx] = 1'b0;
    wait_init(idx);
  endtask

  task automatic send_word(input int idx, input logic [63:0] din, output logic [63:0] dout,
                           output int lat);
    int guard = 0;
    while (!in_ready_s[idx] && guard < 400) begin
      step();
      guard++;
    end
    if (guard >= 400) begin
      checks++;
      errors++;
      $display("FAIL ready_timeout inst %0d: in_ready=%0b required 1", idx, in_ready_s[idx]);
    end
    in_valid_s[idx] = 1'b1;
    data_in_s[idx]  = din;
    step();
    in_valid_s[idx] = 1'b0;
    lat = 0;
    while (!out_valid_s[idx] && lat < 400) begin
      step();
      lat++;
    end
    dout = data_out_s[idx];
    step();
  endtask

  task automatic test_reset();
    bit bad = 0;
    rst = 1'b1;
    step();
    step();
    rst = 1'b0;
    for (int i = 0; i < 3; i++) begin
      checks++;
      if ({busy_s[i], init_done_s[i], in_ready_s[i], out_valid_s[i], data_out_s[i]} !== 68'h0) begin
        errors++;
        $display("FAIL reset_outputs inst %0d: busy=%0b done=%0b in_ready=%0b out_valid=%0b data_out=%h required all 0",
                 i, busy_s[i], init_done_s[i], in_ready_s[i], out_valid_s[i], data_out_s[i]);
      end
    end
    for (int i = 0; i < 3; i++) begin
      in_valid_s[i] = 1'b1;
      data_in_s[i]  = 64'h55;
    end
    for (int c = 0; c < 500; c++) begin
      for (int i = 0; i < 3; i++)
        if (out_valid_s[i] || in_ready_s[i] || busy_s[i] || init_done_s[i]) bad = 1;
      step();
    end
    for (int i = 0; i < 3; i++) in_valid_s[i] = 1'b0;
    checks++;
    if (bad !== 1'b0) begin
      errors++;
      $display("FAIL idle_ignores_in_valid: activity seen=%0b required 0", bad);
    end
    $display("test_reset done");
  endtask

  task automatic test_init_timing();
    int first_busy = -1, last_busy = -1, busy_cnt = 0, first_done = -1;
    key = '0;
    iv  = '0;
    for (int c = 0; c < 10; c++) step();
    start_s[0] = 1'b1;
    step();
    start_s[0] = 1'b0;
    for (int k = 1; k <= 300; k++) begin
      if (busy_s[0]) begin
        if (first_busy < 0) first_busy = k;
        last_busy = k;
        busy_cnt++;
      end
      if (init_done_s[0] && first_done < 0) first_done = k;
      step();
    end
    checks++;
    if (first_busy !== 1 || last_busy !== 256 || busy_cnt !== 256) begin
      errors++;
      $display("FAIL busy_window: first=%0d last=%0d count=%0d required 1 256 256",
               first_busy, last_busy, busy_cnt);
    end
    checks++;
    if (first_done !== 257) begin
      errors++;
      $display("FAIL init_done_rise: cycle=%0d required 257", first_done);
    end
    checks++;
    if (in_ready_s[0] !== 1'b1 || init_done_s[0] !== 1'b1) begin
      errors++;
      $display("FAIL ready_after_init: in_ready=%0b init_done=%0b required 1 1",
               in_ready_s[0], init_done_s[0]);
    end
    $display("test_init_timing first_busy=%0d busy_cnt=%0d first_done=%0d", first_busy, busy_cnt, first_done);
  endtask

  task automatic test_keystream_roundtrip();
    logic [63:0] c0, c1, p0, p1;
    int lat;
    compute_ks(128'h0, 96'h0);
    send_word(0, 64'h0, c0, lat);
    checks++;
    if (c0 !== ks_exp[0] || lat !== 64) begin
      errors++;
      $display("FAIL ks_word0: data_out=%h lat=%0d required %h 64", c0, lat, ks_exp[0]);
    end
    $display("enc word0 out=%h lat=%0d", c0, lat);
    send_word(0, 64'hA5A5_A5A5_A5A5_A5A5, c1, lat);
    checks++;
    if (c1 !== (64'hA5A5_A5A5_A5A5_A5A5 ^ ks_exp[1])) begin
      errors++;
      $display("FAIL ks_word1: data_out=%h required %h", c1, 64'hA5A5_A5A5_A5A5_A5A5 ^ ks_exp[1]);
    end
    $display("enc word1 out=%h lat=%0d", c1, lat);
    do_init(0);
    send_word(0, c0, p0, lat);
    checks++;
    if (p0 !== 64'h0) begin
      errors++;
      $display("FAIL roundtrip0: data_out=%h required 0", p0);
    end
    send_word(0, c1, p1, lat);
    checks++;
    if (p1 !== 64'hA5A5_A5A5_A5A5_A5A5) begin
      errors++;
      $display("FAIL roundtrip1: data_out=%h required a5a5a5a5a5a5a5a5", p1);
    end
    $display("dec words out=%h %h", p0, p1);
  endtask

  task automatic test_parallel();
    logic [63:0] d;
    int lat;
    key = 128'h0123_4567_89AB_CDEF_0123_4567_89AB_CDEF;
    iv  = 96'hFEDC_BA98_7654_3210_FEDC_BA98;
    compute_ks(key, iv);
    for (int i = 0; i < 3; i++) start_s[i] = 1'b1;
    step();
    for (int i = 0; i < 3; i++) start_s[i] = 1'b0;
    for (int i = 0; i < 3; i++) wait_init(i);
    for (int k = 0; k < 4; k++) begin
      for (int i = 0; i < 3; i++) begin
        send_word(i, pat[k], d, lat);
        checks++;
        if (d !== (pat[k] ^ ks_exp[k]) || lat !== lat_exp[i]) begin
          errors++;
          $display("FAIL parallel inst %0d word %0d: data_out=%h lat=%0d required %h %0d",
                   i, k, d, lat, pat[k] ^ ks_exp[k], lat_exp[i]);
        end
        $display("parallel inst %0d word %0d out=%h lat=%0d", i, k, d, lat);
      end
    end
  endtask

  task automatic test_backpressure();
    logic [63:0] held, d;
    int lat, guard = 0;
    bit bad = 0;
    out_ready_s[1] = 1'b0;
    while (!in_ready_s[1] && guard < 400) begin
      step();
      guard++;
    end
    in_valid_s[1] = 1'b1;
    data_in_s[1]  = pat[2];
    step();
    start_s[1] = 1'b1;
    guard = 0;
    while (!out_valid_s[1] && guard < 400) begin
      step();
      guard++;
    end
    held = data_out_s[1];
    for (int c = 0; c < 10; c++) begin
      step();
      if (data_out_s[1] !== held || !out_valid_s[1] || in_ready_s[1] || busy_s[1]) bad = 1;
    end
    checks++;
    if (bad !== 1'b0 || guard >= 400) begin
      errors++;
      $display("FAIL backpressure_hold: unstable=%0b wait=%0d required 0 and < 400", bad, guard);
    end
    checks++;
    if (held !== (pat[2] ^ ks_exp[4])) begin
      errors++;
      $display("FAIL backpressure_data: data_out=%h required %h", held, pat[2] ^ ks_exp[4]);
    end
    start_s[1]     = 1'b0;
    in_valid_s[1]  = 1'b0;
    out_ready_s[1] = 1'b1;
    step();
    checks++;
    if (out_valid_s[1] !== 1'b0 || init_done_s[1] !== 1'b1 || busy_s[1] !== 1'b0) begin
      errors++;
      $display("FAIL backpressure_release: out_valid=%0b init_done=%0b busy=%0b required 0 1 0",
               out_valid_s[1], init_done_s[1], busy_s[1]);
    end
    send_word(1, 64'h0, d, lat);
    checks++;
    if (d !== ks_exp[5] || lat !== 8) begin
      errors++;
      $display("FAIL stream_continues: data_out=%h lat=%0d required %h 8", d, lat, ks_exp[5]);
    end
    $display("backpressure held=%h next=%h", held, d);
  endtask

  task automatic test_collision();
    logic [63:0] d;
    int lat;
    start_s[1]    = 1'b1;
    in_valid_s[1] = 1'b1;
    data_in_s[1]  = 64'hFFFF_FFFF_FFFF_FFFF;
    #1;
    checks++;
    if (in_ready_s[1] !== 1'b0) begin
      errors++;
      $display("FAIL collision_in_ready: in_ready=%0b required 0", in_ready_s[1]);
    end
    step();
    start_s[1]    = 1'b0;
    in_valid_s[1] = 1'b0;
    checks++;
    if (busy_s[1] !== 1'b1 || init_done_s[1] !== 1'b0) begin
      errors++;
      $display("FAIL collision_init: busy=%0b init_done=%0b required 1 0", busy_s[1], init_done_s[1]);
    end
    wait_init(1);
    send_word(1, pat[3], d, lat);
    checks++;
    if (d !== (pat[3] ^ ks_exp[0])) begin
      errors++;
      $display("FAIL collision_restart: data_out=%h required %h", d, pat[3] ^ ks_exp[0]);
    end
    $display("collision restart word out=%h", d);
  endtask

  task automatic test_reset_mid_gen();
    bit bad = 0;
    in_valid_s[0] = 1'b1;
    data_in_s[0]  = pat[1];
    step();
    in_valid_s[0] = 1'b0;
    step();
    step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    checks++;
    if ({busy_s[0], init_done_s[0], in_ready_s[0], out_valid_s[0], data_out_s[0]} !== 68'h0) begin
      errors++;
      $display("FAIL reset_mid_gen: busy=%0b done=%0b in_ready=%0b out_valid=%0b data_out=%h required all 0",
               busy_s[0], init_done_s[0], in_ready_s[0], out_valid_s[0], data_out_s[0]);
    end
    for (int c = 0; c < 100; c++) begin
      if (out_valid_s[0] || in_ready_s[0]) bad = 1;
      step();
    end
    checks++;
    if (bad !== 1'b0) begin
      errors++;
      $display("FAIL reset_no_output: out_valid/in_ready seen=%0b required 0", bad);
    end
    $display("test_reset_mid_gen done");
  endtask

  initial begin
    rst = 1'b1;
    key = '0;
    iv  = '0;
    for (int i = 0; i < 3; i++) begin
      start_s[i]     = 1'b0;
      in_valid_s[i]  = 1'b0;
      out_ready_s[i] = 1'b1;
      data_in_s[i]   = '0;
    end
    test_reset();
    test_init_timing();
    test_keystream_roundtrip();
    test_parallel();
    test_backpressure();
    test_collision();
    test_reset_mid_gen();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/fountain_v2_keystream.md
Name: fountain_v2_keystream

Overview:
Parametrised successor to the v1 serial Fountain core. It loads a 128-bit key and a 96-bit IV, then runs a fixed warm-up. After warm-up it XORs a keystream onto a stream of DATA_W-bit words using a valid/ready handshake on both sides. STEP_W keystream bits are produced per clock, which trades area for throughput. The block sits between the host interface and the AEAD wrapper.

Parameters:
DATA_W, 64, data word width; must be a multiple of STEP_W.
STEP_W, 1, keystream bits per clock; legal values 1, 2, 4, 8, 16, 32.
WARMUP_BITS, 256, warm-up shifts after load; must be a multiple of STEP_W.

Ports:
clk  in  1  clock; all logic on the rising edge.
rst  in  1  synchronous reset, active-high.
start  in  1  single-cycle init request; samples key and iv.
key  in  128  secret key.
iv  in  96  initialisation vector.
busy  out  1  high while in INIT.
init_done  out  1  high while in READY, GEN or OUT after a completed init.
in_valid  in  1  data_in valid.
in_ready  out  1  high only in READY when start=0.
data_in  in  DATA_W  plaintext or ciphertext word.
out_valid  out  1  data_out valid.
out_ready  in  1  downstream accepts data_out.
data_out  out  DATA_W  data_in XOR keystream.

Behaviour:
- State: L[127:0] (LFSR) and N[127:0] (NFSR). One shift moves each register right by 1; the new bit enters at index 127.
- f = L0^L7^L38^L70^L81^L96.
- g = L0^N0^N26^N56^N91^N96^(N3&N67)^(N11&N13)^(N17&N18).
- z = N2^N15^N36^N45^N64^N73^N89^L93^(L8&N12)^(L13&L20).
- Warm-up shift: L127 <= f^z, N127 <= g^z.
- Keystream shift: L127 <= f, N127 <= g; output z.
- STEP_W shifts per clock are unrolled combinationally. Bit j of a step equals the j-th serial shift, so results are bit-identical for every STEP_W.
- Load on accepted start: N <= key; L <= {32'hFFFF_FFFE, iv}, with iv in L[95:0].
- Word bit order: keystream bit i (the i-th shift of the word) XORs data_in[i], LSB first. data_in is registered on acceptance.
- FSM:
  - IDLE: start -> load, go to INIT.
  - INIT: WARMUP_BITS/STEP_W clocks, then go to READY.
  - READY:
    - start -> reload, go to INIT.
    - else in_valid -> accept the word, go to GEN.
  - GEN: DATA_W/STEP_W clocks, then go to OUT.
  - OUT: hold data_out and out_valid until out_ready, then go to READY. Both in_ready and out_valid are combinational from state, so there is no same-cycle bypass.
- Latency:
  - busy rises the cycle after start and stays high exactly WARMUP_BITS/STEP_W cycles; init_done rises the next cycle.
  - out_valid rises DATA_W/STEP_W cycles after the accepting edge.
  - Throughput is one word per DATA_W/STEP_W+2 cycles with out_ready=1.
- Simultaneous start and in_valid in READY: start wins; in_ready=0, so the word is not accepted.
- start during INIT, GEN or OUT is ignored; no restart occurs and data is not lost.
- in_valid in IDLE or INIT is ignored (in_ready=0).
- Reset values: FSM=IDLE; L, N and data_out cleared to 0; busy=0; init_done=0; in_ready=0; out_valid=0.
- Reset mid-operation: same as above on the next edge. Any pending word is discarded and a new start is required.
- Keystream continues across words without reset; word k uses shifts k*DATA_W .. k*DATA_W+DATA_W-1 after warm-up.

Test Plan:
- Reset/idle:
  - Stimulus: rst=1 for 2 cycles, then in_valid=1, data_in=64'h55.
  - Required: all outputs 0; in_ready=0; no out_valid for 500 cycles.
- Init timing, STEP_W=1:
  - Stimulus: key=0, iv=0, start pulse at cycle 10.
  - Required: busy high exactly cycles 11..266; init_done=1 from cycle 267; in_ready=1.
- Keystream and round-trip:
  - Stimulus: after init, encrypt 64'h0, then 64'hA5A5_A5A5_A5A5_A5A5.
  - Required: first out equals the golden-model keystream word 0. Re-init with the same key/iv and feed the ciphertexts back; outputs return 0 and A5A5..A5.
- Parallel equivalence:
  - Stimulus: STEP_W=1, 8 and 32 instances; key=128'h0123..CDEF, iv=96'hFEDC..; 4 words each.
  - Required: identical data_out sequences. Required out_valid latency is 64, 8 and 2 cycles.
- Backpressure:
  - Stimulus: out_ready=0 for 10 cycles in OUT, with in_valid and start held high.
  - Required: data_out stable; in_ready=0; no re-init; the word completes once out_ready=1.
- Reset mid-GEN and start/in_valid collision:
  - Stimulus: rst at GEN cycle 3.
  - Required: IDLE next edge; out_valid never asserted.
  - Stimulus: start=1 and in_valid=1 together in READY.
  - Required: INIT entered; word not consumed.
